bsg_manycore_mem_responder: RTL and testbench

Endpoint-side memory responder. It is the serving end of the remote load/store protocol that tiles issue through their network TX path. It sits behind a `bsg_manycore_endpoint_standard` instance, typically as a scratchpad or test memory on a mesh edge. It accepts incoming requests, performs each one against an internal synchronous single-port word memory, and returns load data, sign- or zero-extended per the request's load info, exactly one cycle after acceptance. A reset-time zeroing sequence can be compiled in.

---
 rtl/bsg_manycore_mem_responder_if.sv | 28 ++
 rtl/bsg_manycore_mem_responder.sv | 118 +++++++++++
 tb/tb_bsg_manycore_mem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/response bundle between a manycore endpoint and the memory responder.
// load_info layout: [6] float_wb, [5] icache_fetch, [4] is_unsigned_op, [3] is_byte_op, [2] is_hex_op, [1:0] part_sel.
interface bsg_manycore_mem_responder_if #(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 12,
    parameter int load_info_width_p = 7
);
    logic                           in_v_i;
    logic                           in_we_i;
    logic [addr_width_p-1:0]        in_addr_i;
    logic [data_width_p-1:0]        in_data_i;
    logic [(data_width_p/8)-1:0]    in_mask_i;
    logic [load_info_width_p-1:0]   in_load_info_i;
    logic                           in_yumi_o;
    logic                           returning_v_o;
    logic [data_width_p-1:0]        returning_data_o;
    logic                           ready_o;

    modport slave (
        input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
        output in_yumi_o, returning_v_o, returning_data_o, ready_o
    );

    modport master (
        output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
        input  in_yumi_o, returning_v_o, returning_data_o, ready_o
    );
endinterface

// File: rtl/bsg_manycore_mem_responder.sv
// Endpoint-side memory responder: single-port word memory, one request per cycle, 1-cycle load return.
// Optional reset-time zeroing sweep enabled by defining BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN.
module bsg_manycore_mem_responder #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 12,
    parameter int mem_els_p    = 1024
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    bsg_manycore_mem_responder_if.slave  bus
);
    localparam int mem_addr_width_lp = (mem_els_p == 1) ? 1 : $clog2(mem_els_p);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e r_state, w_state_next;

`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
    localparam state_e reset_state_lp = S_INIT;
    localparam logic [mem_addr_width_lp:0] init_last_lp = (mem_addr_width_lp+1)'(mem_els_p - 1);
    logic [mem_addr_width_lp:0] r_init_cnt;
`else
    localparam state_e reset_state_lp = S_READY;
`endif

    logic [data_width_p-1:0]      r_mem [mem_els_p];
    logic [data_width_p-1:0]      r_rdata;
    logic                         r_v, r_was_load, r_unsigned, r_byte, r_hex;
    logic [1:0]                   r_part_sel;
    logic                         w_yumi, w_init_we, w_unused;
    logic [mem_addr_width_lp-1:0] w_addr;
    logic [7:0]                   w_byte;
    logic [15:0]                  w_half;
    logic [data_width_p-1:0]      w_resp;

    assign w_addr   = bus.in_addr_i[mem_addr_width_lp-1:0];
    assign w_unused = ^{bus.in_addr_i, bus.in_load_info_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= reset_state_lp;
        else         r_state <= w_state_next;
    end

    // Requests arriving while reset is held are never consumed.
    always_comb begin
        w_state_next = r_state;
        w_yumi       = 1'b0;
        case (r_state)
            S_INIT: begin
`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
                if (r_init_cnt == init_last_lp) w_state_next = S_READY;
`else
                w_state_next = S_READY;
`endif
            end
            S_READY: w_yumi = bus.in_v_i & ~reset_i;
            default: w_state_next = reset_state_lp;
        endcase
    end

`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
    assign w_init_we = (r_state == S_INIT) & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i)        r_init_cnt <= '0;
        else if (w_init_we) r_init_cnt <= r_init_cnt + 1'b1;
    end
`else
    assign w_init_we = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
        if (w_init_we) r_mem[r_init_cnt[mem_addr_width_lp-1:0]] <= '0;
`endif
        if (w_yumi && bus.in_we_i) begin
            for (int k = 0; k < data_width_p/8; k++) begin
                if (bus.in_mask_i[k]) r_mem[w_addr][8*k +: 8] <= bus.in_data_i[8*k +: 8];
            end
        end
        if (w_yumi && !bus.in_we_i) r_rdata <= r_mem[w_addr];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v        <= 1'b0;
            r_was_load <= 1'b0;
            r_unsigned <= 1'b0;
            r_byte     <= 1'b0;
            r_hex      <= 1'b0;
            r_part_sel <= 2'b00;
        end else begin
            r_v        <= w_yumi;
            r_was_load <= w_yumi & ~bus.in_we_i;
            if (w_yumi && !bus.in_we_i) begin
                r_unsigned <= bus.in_load_info_i[4];
                r_byte     <= bus.in_load_info_i[3];
                r_hex      <= bus.in_load_info_i[2];
                r_part_sel <= bus.in_load_info_i[1:0];
            end
        end
    end

    // Hex wins over byte when both flags are set.
    always_comb begin
        w_byte = r_rdata[{r_part_sel, 3'b000} +: 8];
        w_half = r_part_sel[1] ? r_rdata[31:16] : r_rdata[15:0];
        w_resp = r_rdata;
        if (r_hex)       w_resp = {{16{~r_unsigned & w_half[15]}}, w_half};
        else if (r_byte) w_resp = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        if (!r_was_load) w_resp = '0;
    end

    assign bus.in_yumi_o        = w_yumi;
    assign bus.returning_v_o    = r_v;
    assign bus.returning_data_o = w_resp;
    assign bus.ready_o          = (r_state == S_READY) & ~reset_i;
endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Scoreboard bench for bsg_manycore_mem_responder; adapts to BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN.
module tb_bsg_manycore_mem_responder;
    localparam int AW  = 12;
    localparam int ELS = 1024;
`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
    localparam int INIT_CYCLES = ELS;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    bsg_manycore_mem_responder_if #(.data_width_p(32), .addr_width_p(AW), .load_info_width_p(7)) bus ();

    bsg_manycore_mem_responder #(.data_width_p(32), .addr_width_p(AW), .mem_els_p(ELS)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [ELS];
    logic [31:0] exp_q [$];
    logic        prev_yumi  = 1'b0;
    logic        prev_reset = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] mk_info(input bit uns, input bit byt, input bit hex, input bit [1:0] ps);
        return {2'b00, uns, byt, hex, ps};
    endfunction

    // Reference load formatting written as plain shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [6:0] info);
        int unsigned v;
        int          bits;
        if (info[2]) begin
            v    = (w >> (16 * int'(info[1]))) & 32'hFFFF;
            bits = 16;
        end else if (info[3]) begin
            v    = (w >> (8 * int'(info[1:0]))) & 32'hFF;
            bits = 8;
        end else begin
            return w;
        end
        if (!info[4] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic issue(input bit sync, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] data, input logic [3:0] mask, input logic [6:0] info,
                         output int waited);
        int          n;
        int          idx;
        logic [31:0] bm;
        if (sync) begin
            @(posedge clk_i);
            #1;
        end
        bus.in_v_i         = 1'b1;
        bus.in_we_i        = we;
        bus.in_addr_i      = addr;
        bus.in_data_i      = data;
        bus.in_mask_i      = mask;
        bus.in_load_info_i = info;
        #1;
        n = 0;
        while (bus.in_yumi_o !== 1'b1 && n < 3000) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        waited = n;
        if (bus.in_yumi_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL yumi_timeout: got no yumi after %0d cycles, required yumi", n);
        end else begin
            idx = int'(addr) % ELS;
            if (we) begin
                bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
                model[idx] = (model[idx] & ~bm) | (data & bm);
                exp_q.push_back(32'h0);
            end else begin
                exp_q.push_back(ref_load(model[idx], info));
            end
        end
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
        bus.in_v_i = 1'b0;
    endtask

    // Called at posedge+1 while reset is high; cycle 0 is the current cycle.
    task automatic release_and_count();
        int w;
        reset_i = 1'b0;
`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
        for (int i = 0; i < ELS; i++) model[i] = 32'h0;
`endif
        #1;
        chk("ready_after_reset", {31'b0, bus.ready_o}, (INIT_CYCLES == 0) ? 32'd1 : 32'd0);
        #0;
`ifdef BSG_MANYCORE_MEM_RESPONDER_ZERO_INIT_EN
        issue(1'b0, 1'b0, 12'd5, 32'h0, 4'h0, mk_info(0, 0, 0, 2'd0), w);
`else
        issue(1'b0, 1'b1, 12'd5, 32'h0, 4'hF, mk_info(0, 0, 0, 2'd0), w);
`endif
        chk("init_length", w, INIT_CYCLES);
        chk("ready_when_accepting", {31'b0, bus.ready_o}, 32'd1);
    endtask

    always @(negedge clk_i) begin
        logic [31:0] e;
        n_cmp++;
        if (bus.returning_v_o !== (prev_yumi & ~prev_reset)) begin
            n_bad++;
            $display("FAIL resp_latency: returning_v_o=%b required %b", bus.returning_v_o, prev_yumi & ~prev_reset);
        end
        if (bus.returning_v_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: data %h with empty scoreboard", bus.returning_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", bus.returning_data_o, e);
            end
        end
        prev_yumi  = bus.in_yumi_o;
        prev_reset = reset_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic        we;
        logic [AW-1:0] a;

        bus.in_v_i         = 1'b0;
        bus.in_we_i        = 1'b0;
        bus.in_addr_i      = '0;
        bus.in_data_i      = '0;
        bus.in_mask_i      = '0;
        bus.in_load_info_i = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_yumi", {31'b0, bus.in_yumi_o}, 32'd0);
        chk("rst_v", {31'b0, bus.returning_v_o}, 32'd0);
        chk("rst_data", bus.returning_data_o, 32'd0);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'd0);

        @(posedge clk_i);
        #1;
        release_and_count();

        issue(1, 1, 12'd3, 32'hCAFEBABE, 4'hF, mk_info(0, 0, 0, 0), w);
        issue(1, 0, 12'd3, 32'h0, 4'h0, mk_info(0, 0, 0, 0), w);

        issue(1, 1, 12'd7, 32'hAABBCCDD, 4'hF, mk_info(0, 0, 0, 0), w);
        issue(1, 1, 12'd7, 32'h11223344, 4'h5, mk_info(0, 0, 0, 0), w);
        issue(1, 1, 12'd7, 32'hFFFFFFFF, 4'h0, mk_info(0, 0, 0, 0), w);
        issue(1, 0, 12'd7, 32'h0, 4'h0, mk_info(0, 0, 0, 0), w);

        issue(1, 1, 12'd9, 32'h80FF7F01, 4'hF, mk_info(0, 0, 0, 0), w);
        issue(1, 0, 12'd9, 32'h0, 4'h0, mk_info(0, 1, 0, 2'd3), w);
        issue(1, 0, 12'd9, 32'h0, 4'h0, mk_info(1, 1, 0, 2'd2), w);
        issue(1, 0, 12'd9, 32'h0, 4'h0, mk_info(0, 0, 1, 2'd2), w);
        issue(1, 0, 12'd9, 32'h0, 4'h0, mk_info(1, 0, 1, 2'd0), w);
        issue(1, 0, 12'd9, 32'h0, 4'h0, mk_info(0, 1, 1, 2'd1), w);

        issue(1, 1, 12'h400, 32'h12345678, 4'hF, mk_info(0, 0, 0, 0), w);
        issue(1, 0, 12'h000, 32'h0, 4'h0, mk_info(0, 0, 0, 0), w);
        idle();

        for (int i = 16; i < 32; i++) issue(1, 1, AW'(i), $urandom, 4'hF, 7'h0, w);
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = AW'(16 + $urandom_range(0, 15) + 1024 * $urandom_range(0, 3));
            issue(1, we, a, $urandom, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)), w);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        repeat (3) @(posedge clk_i);

        issue(1, 0, 12'd9, 32'h0, 4'h0, mk_info(0, 0, 0, 0), w);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        bus.in_addr_i = 12'd3;
        @(posedge clk_i);
        #1;
        chk("v_after_reset", {31'b0, bus.returning_v_o}, 32'd0);
        release_and_count();
        idle();

        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
